maxpool2x2_stream: RTL and testbench

Streaming 2x2 / stride-2 max-pooling unit for FP16 (IEEE binary16) feature maps, successor to the combinational four-input pooling block. It accepts one pixel per beat in raster order over a valid/ready interface, buffers half a row of horizontal pair maxima, and emits one pooled pixel per 2x2 window. It sits between a convolution/activation stage and the next encoder level of the U-Net datapath, with CH channels processed in parallel lanes.

---
 rtl/maxpool2x2_stream.sv | 138 +++++++++++++
 tb/tb_maxpool2x2_stream.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 FP16 max-pool over raster-order pixels, CH lanes per beat.
// Define POOL_INDEX_EN to add out_idx, the per-lane argmax position used for max-unpooling.
module maxpool2x2_stream #(
  parameter int DATA_W = 16,
  parameter int CH     = 1,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last
`ifdef POOL_INDEX_EN
  ,
  output logic [CH*2-1:0]      out_idx
`endif
);

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int HALF  = IMG_W / 2;
  localparam int LB_AW = (HALF > 1) ? $clog2(HALF) : 1;

  // Strict "x beats y": ties, including +0 vs -0, leave the earlier element in place.
  function automatic logic isGreater(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [DATA_W-2:0] magX;
    logic [DATA_W-2:0] magY;
    magX = x[DATA_W-2:0];
    magY = y[DATA_W-2:0];
    if (magX == '0 && magY == '0) return 1'b0;
    if (x[DATA_W-1] != y[DATA_W-1]) return !x[DATA_W-1];
    if (!x[DATA_W-1]) return magX > magY;
    return magX < magY;
  endfunction

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [CH*DATA_W-1:0] hold;
  logic [CH*DATA_W-1:0] lineBuf [HALF];
  logic [LB_AW-1:0]    lbAddr;
  logic [CH*DATA_W-1:0] lineRd;
  logic [CH*DATA_W-1:0] pairMax;
  logic [CH*DATA_W-1:0] quadMax;
  logic [CH-1:0]       pairSel;
  logic [CH-1:0]       quadSel;
  logic                accept;
  logic                windowDone;
  logic                frameEnd;
  logic                outValidQ;

  assign in_ready   = !outValidQ || out_ready;
  assign out_valid  = outValidQ;
  assign accept     = in_valid && in_ready;
  assign lbAddr     = LB_AW'(col >> 1);
  assign lineRd     = lineBuf[lbAddr];
  assign windowDone = accept && col[0] && row[0];
  assign frameEnd   = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

  // Horizontal pair uses the held even-column pixel; the vertical step uses the stored top pair.
  always_comb begin
    pairMax = '0;
    quadMax = '0;
    pairSel = '0;
    quadSel = '0;
    for (int c = 0; c < CH; c++) begin
      pairSel[c] = isGreater(in_data[c*DATA_W +: DATA_W], hold[c*DATA_W +: DATA_W]);
      pairMax[c*DATA_W +: DATA_W] = pairSel[c] ? in_data[c*DATA_W +: DATA_W]
                                                : hold[c*DATA_W +: DATA_W];
      quadSel[c] = isGreater(pairMax[c*DATA_W +: DATA_W], lineRd[c*DATA_W +: DATA_W]);
      quadMax[c*DATA_W +: DATA_W] = quadSel[c] ? pairMax[c*DATA_W +: DATA_W]
                                                : lineRd[c*DATA_W +: DATA_W];
    end
  end

`ifdef POOL_INDEX_EN
  logic [CH-1:0]   lineIdx [HALF];
  logic [CH-1:0]   lineIdxRd;
  logic [CH*2-1:0] quadIdx;

  assign lineIdxRd = lineIdx[lbAddr];

  always_comb begin
    quadIdx = '0;
    for (int c = 0; c < CH; c++) begin
      quadIdx[c*2 +: 2] = quadSel[c] ? {1'b1, pairSel[c]} : {1'b0, lineIdxRd[c]};
    end
  end

  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) lineIdx[lbAddr] <= pairSel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_idx <= '0;
    else if (windowDone) out_idx <= quadIdx;
  end
`endif

  // Hold and line buffer are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col[0]) hold <= in_data;
      else if (!row[0]) lineBuf[lbAddr] <= pairMax;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      outValidQ <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (windowDone) begin
        outValidQ <= 1'b1;
        out_data  <= quadMax;
        out_last  <= frameEnd;
      end else if (out_ready) begin
        outValidQ <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: random frames against a numeric-order reference model.
// Index checks are active when POOL_INDEX_EN is defined.
module tb_maxpool2x2_stream;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  typedef struct {
    logic [CH*16-1:0] data;
    logic [CH*2-1:0]  idx;
    logic             last;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CH*16-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH*16-1:0] out_data;
  logic             out_last;
`ifdef POOL_INDEX_EN
  logic [CH*2-1:0]  out_idx;
`endif

  exp_t             expQ [$];
  logic [CH*16-1:0] frameBuf [NPIX];
  logic [15:0]      dirTop [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                   16'hC000, 16'hB800, 16'hC200, 16'hBC00};
  logic [15:0]      dirBot [8] = '{16'h4500, 16'h3800, 16'hBC00, 16'h4800,
                                   16'h8000, 16'h0000, 16'hC400, 16'hC000};
  logic [15:0]      dirVal [4] = '{16'h4500, 16'h4800, 16'h8000, 16'hBC00};
  int               dirIdx [4] = '{2, 3, 2, 1};

  int total = 0;
  int bad   = 0;
  int readyMode = 0;
  int stallCnt  = 0;
  bit stallDone = 0;
  bit stallPrev = 0;
  logic [CH*16-1:0] stallData;
  logic             stallLast;

  maxpool2x2_stream #(.DATA_W(16), .CH(CH), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
`ifdef POOL_INDEX_EN
    ,
    .out_idx(out_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Numeric ordering of FP16 bit patterns: sign-magnitude mapped to a signed integer.
  function automatic int fpKey(input logic [15:0] v);
    int m;
    m = int'(v[14:0]);
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] rndVal();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h3C00;
      3: return 16'hBC00;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic fillRandom();
    for (int i = 0; i < NPIX; i++)
      for (int c = 0; c < CH; c++) frameBuf[i][c*16 +: 16] = rndVal();
  endtask

  task automatic applyDirected();
    for (int x = 0; x < 8; x++) begin
      frameBuf[x][15:0]     = dirTop[x];
      frameBuf[W + x][15:0] = dirBot[x];
    end
  endtask

  task automatic pushFrameExpect(input bit directed);
    for (int wr = 0; wr < H / 2; wr++) begin
      for (int wc = 0; wc < W / 2; wc++) begin
        exp_t e;
        e.data = '0;
        e.idx  = '0;
        e.last = (wr == H / 2 - 1) && (wc == W / 2 - 1);
        for (int c = 0; c < CH; c++) begin
          int bestKey;
          int bestP;
          logic [15:0] bestV;
          bestKey = 0;
          bestP   = 0;
          bestV   = '0;
          for (int p = 0; p < 4; p++) begin
            logic [15:0] v;
            v = frameBuf[(2 * wr + p / 2) * W + 2 * wc + p % 2][c*16 +: 16];
            if (p == 0 || fpKey(v) > bestKey) begin
              bestKey = fpKey(v);
              bestP   = p;
              bestV   = v;
            end
          end
          if (directed && wr == 0 && c == 0) begin
            bestV = dirVal[wc];
            bestP = dirIdx[wc];
          end
          e.data[c*16 +: 16] = bestV;
          e.idx[c*2 +: 2]    = 2'(bestP);
        end
        expQ.push_back(e);
      end
    end
  endtask

  // Called and returns at posedge+1.
  task automatic sendPixel(input logic [CH*16-1:0] d, input bit gaps);
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 2000) begin
        total++;
        bad++;
        $display("FAIL in_ready_timeout: in_ready stuck at %0b, required 1", in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input bit gaps);
    for (int i = 0; i < NPIX; i++) sendPixel(frameBuf[i], gaps);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (expQ.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    check("drain_pending", 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (!stallDone && out_valid) begin
            out_ready = 1'b0;
            stallCnt++;
            if (stallCnt >= 5) stallDone = 1'b1;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got data %0h, required no output", out_data);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", 64'(out_last), 64'(e.last));
`ifdef POOL_INDEX_EN
          check("out_idx", 64'(out_idx), 64'(e.idx));
`endif
        end
      end
      if (stallPrev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, stallData);
        check("stall_last", 64'(out_last), 64'(stallLast));
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        stallPrev = 1'b1;
        stallData = out_data;
        stallLast = out_last;
      end else begin
        stallPrev = 1'b0;
      end
    end else begin
      stallPrev = 1'b0;
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
`ifdef POOL_INDEX_EN
    check("rst_out_idx", 64'(out_idx), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    readyMode = 0;
    fillRandom();
    applyDirected();
    pushFrameExpect(1'b1);
    sendFrame(1'b0);
    drain();

    stallCnt  = 0;
    stallDone = 1'b0;
    readyMode = 2;
    fillRandom();
    pushFrameExpect(1'b0);
    sendFrame(1'b0);
    drain();
    check("stall_cycles", 64'(stallCnt), 64'd5);

    readyMode = 1;
    fillRandom();
    pushFrameExpect(1'b0);
    sendFrame(1'b1);
    fillRandom();
    pushFrameExpect(1'b0);
    sendFrame(1'b1);
    drain();

    readyMode = 0;
    fillRandom();
    for (int i = 0; i < 5; i++) sendPixel(frameBuf[i], 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_data", out_data, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fillRandom();
    pushFrameExpect(1'b0);
    sendFrame(1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
